// File: rtl/lsu_mem.sv
// ---------------------------------------------------------------------------
// lsu_mem : memory-access stage placed after execute.
//
// Load/store instructions run one request/acknowledge transaction on a 32-bit
// word-addressed data bus. The stage places store data in the correct byte
// lanes and sign- or zero-extends load data. Every other opcode forwards
// alu_result to writeback after one cycle. in_ready is low while an
// instruction is in flight, which stalls the core.
//
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   in_valid / in_ready       handshake from execute
//   operation, funct3         opcode and width/sign select
//   alu_result, data_rs2      effective address (or ALU result), store data
//   mem_req/we/addr/wdata/wstrb  bus request, held until ack or timeout
//   mem_ack, mem_rdata        bus completion and read word
//   out_valid, wb_data, err   one-cycle writeback pulse; err qualifies it
//
// States
//   S_IDLE | waiting for an instruction; in_ready high
//   S_REQ  | bus request outstanding; timeout counter running
//   S_RESP | out_valid pulse with wb_data/err
// ---------------------------------------------------------------------------
module lsu_mem #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [6:0]  OP_LOAD        = 7'b0000011,
    parameter logic [6:0]  OP_STORE       = 7'b0100011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  operation,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_result,
    input  logic [31:0] data_rs2,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    output logic [31:0] wb_data,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
    } state_t;

    // Timeout fires on the REQ cycle whose count would reach TIMEOUT_CYCLES.
    localparam logic [7:0] LP_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [2:0]  r_f3;
    logic [1:0]  r_addr_lo;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_out_valid;
    logic [31:0] r_wb_data;
    logic        r_err;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_f3_ok;
    logic        w_misaligned;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_val;

    assign w_is_load  = (operation == OP_LOAD);
    assign w_is_store = (operation == OP_STORE);

    // Legal funct3: loads LB/LH/LW/LBU/LHU, stores SB/SH/SW.
    always_comb begin
        w_f3_ok = 1'b0;
        if (w_is_load)
            w_f3_ok = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
        else if (w_is_store)
            w_f3_ok = (funct3[2] == 1'b0) && (funct3[1:0] != 2'b11);
    end

    // funct3[1:0] encodes the access size for both loads and stores.
    always_comb begin
        w_misaligned = 1'b0;
        case (funct3[1:0])
            2'b01:   w_misaligned = alu_result[0];
            2'b10:   w_misaligned = (alu_result[1:0] != 2'b00);
            default: w_misaligned = 1'b0;
        endcase
    end

    // Store lane placement: data replicated, strobes select the lanes written.
    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = 32'h0;
        case (funct3[1:0])
            2'b00: begin
                w_wstrb = 4'b0001 << alu_result[1:0];
                w_wdata = {4{data_rs2[7:0]}};
            end
            2'b01: begin
                w_wstrb = 4'b0011 << {alu_result[1], 1'b0};
                w_wdata = {2{data_rs2[15:0]}};
            end
            default: begin
                w_wstrb = 4'b1111;
                w_wdata = data_rs2;
            end
        endcase
    end

    // Load lane extraction uses the byte offset latched at acceptance.
    always_comb begin
        w_byte = 8'h00;
        case (r_addr_lo)
            2'b00:   w_byte = mem_rdata[7:0];
            2'b01:   w_byte = mem_rdata[15:8];
            2'b10:   w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = r_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    end

    always_comb begin
        w_load_val = mem_rdata;
        case (r_f3)
            3'b000:  w_load_val = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_val = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_val = {24'h0, w_byte};
            3'b101:  w_load_val = {16'h0, w_half};
            default: w_load_val = mem_rdata;
        endcase
    end

    assign in_ready = (r_state == S_IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'h00;
            r_f3        <= 3'b000;
            r_addr_lo   <= 2'b00;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_wstrb     <= 4'b0000;
            r_out_valid <= 1'b0;
            r_wb_data   <= 32'h0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_out_valid <= 1'b0;
                    r_err       <= 1'b0;
                    r_wb_data   <= 32'h0;
                    if (in_valid) begin
                        r_f3      <= funct3;
                        r_addr_lo <= alu_result[1:0];
                        if (!w_is_load && !w_is_store) begin
                            r_state     <= S_RESP;
                            r_out_valid <= 1'b1;
                            r_wb_data   <= alu_result;
                        end else if (!w_f3_ok || w_misaligned) begin
                            r_state     <= S_RESP;
                            r_out_valid <= 1'b1;
                            r_err       <= 1'b1;
                        end else begin
                            r_state <= S_REQ;
                            r_cnt   <= 8'h00;
                            r_req   <= 1'b1;
                            r_we    <= w_is_store;
                            r_addr  <= {alu_result[31:2], 2'b00};
                            r_wdata <= w_is_store ? w_wdata : 32'h0;
                            r_wstrb <= w_is_store ? w_wstrb : 4'b0000;
                        end
                    end
                end

                S_REQ: begin
                    // Ack takes priority over a timeout on the same cycle.
                    if (mem_ack) begin
                        r_state     <= S_RESP;
                        r_cnt       <= 8'h00;
                        r_req       <= 1'b0;
                        r_we        <= 1'b0;
                        r_wstrb     <= 4'b0000;
                        r_out_valid <= 1'b1;
                        r_wb_data   <= r_we ? 32'h0 : w_load_val;
                        r_err       <= 1'b0;
                    end else if (r_cnt == LP_LAST) begin
                        r_state     <= S_RESP;
                        r_cnt       <= 8'h00;
                        r_req       <= 1'b0;
                        r_we        <= 1'b0;
                        r_wstrb     <= 4'b0000;
                        r_out_valid <= 1'b1;
                        r_wb_data   <= 32'h0;
                        r_err       <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'h01;
                    end
                end

                S_RESP: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_wb_data   <= 32'h0;
                    r_err       <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_req   = r_req;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_wstrb = r_wstrb;
    assign out_valid = r_out_valid;
    assign wb_data   = r_wb_data;
    assign err       = r_err;

endmodule

// File: tb/tb_lsu_mem.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem : directed scoreboard bench for lsu_mem (TIMEOUT_CYCLES = 4).
// The stimulus pushes expected writeback results and bus requests into queues.
// Monitor processes compare them whenever out_valid or mem_req is seen.
// ---------------------------------------------------------------------------
module tb_lsu_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  operation;
    logic [2:0]  funct3;
    logic [31:0] alu_result;
    logic [31:0] data_rs2;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic [31:0] wb_data;
    logic        err;

    lsu_mem #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .operation(operation), .funct3(funct3),
        .alu_result(alu_result), .data_rs2(data_rs2),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .wb_data(wb_data), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] wb;
        logic        err;
        int          lat;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } bus_t;

    exp_t exp_q[$];
    bus_t bus_q[$];

    int  checks   = 0;
    int  failures = 0;
    int  ack_delay = 100;
    int  req_cycles = 0;
    int  req_len = 0;
    int  last_req_len = 0;
    logic prev_req = 1'b0;
    time acc_time = 0;

    localparam logic [6:0] OP_ALU = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    // Bus slave: acknowledge on the (ack_delay+1)-th cycle of a request.
    always @(negedge clk) begin
        if (mem_req) begin
            mem_ack = (req_cycles == ack_delay);
            req_cycles++;
        end else begin
            mem_ack = 1'b0;
            req_cycles = 0;
        end
    end

    // Writeback monitor.
    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wb_data", wb_data, e.wb);
                chk("err", 32'(err), 32'(e.err));
                chk("in_ready_in_resp", 32'(in_ready), 32'd0);
                chk("latency", 32'(int'(($time - acc_time + 5) / 10)), 32'(e.lat));
            end
        end
    end

    // Bus monitor: request fields must match and stay stable while mem_req is high.
    always @(negedge clk) begin
        if (mem_req) begin
            req_len++;
            if (bus_q.size() == 0) begin
                chk("unexpected_mem_req", 32'(mem_req), 32'd0);
            end else begin
                chk("mem_we", 32'(mem_we), 32'(bus_q[0].we));
                chk("mem_addr", mem_addr, bus_q[0].addr);
                chk("mem_wstrb", 32'(mem_wstrb), 32'(bus_q[0].wstrb));
                if (bus_q[0].we)
                    chk("mem_wdata", mem_wdata, bus_q[0].wdata);
                chk("in_ready_in_req", 32'(in_ready), 32'd0);
            end
        end
        if (prev_req && !mem_req) begin
            last_req_len = req_len;
            req_len = 0;
            if (bus_q.size() != 0) void'(bus_q.pop_front());
        end
        prev_req = mem_req;
    end

    task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] rs2,
                         input logic want_exp, input logic [31:0] ewb,
                         input logic eerr, input int elat,
                         input logic want_bus, input logic bwe,
                         input logic [31:0] baddr, input logic [31:0] bwdata,
                         input logic [3:0] bwstrb);
        exp_t e;
        bus_t b;
        if (want_exp) begin
            e.wb = ewb; e.err = eerr; e.lat = elat;
            exp_q.push_back(e);
        end
        if (want_bus) begin
            b.we = bwe; b.addr = baddr; b.wdata = bwdata; b.wstrb = bwstrb;
            bus_q.push_back(b);
        end
        last_req_len = 0;
        operation  = op;
        funct3     = f3;
        alu_result = alu;
        data_rs2   = rs2;
        in_valid   = 1'b1;
        @(posedge clk);
        acc_time = $time;
        #1;
        in_valid   = 1'b0;
        alu_result = 32'hDEAD_0000;
        data_rs2   = 32'h0;
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && bus_q.size() == 0 && in_ready) done = 1'b1;
        end
        if (!done) chk("wait_idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        operation = 7'h0;
        funct3 = 3'h0;
        alu_result = 32'h0;
        data_rs2 = 32'h0;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        #1;
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // ALU passthrough
        issue(OP_ALU, 3'b000, 32'h0000_1234, 32'h0, 1, 32'h0000_1234, 0, 1, 0, 0, 0, 0, 0);
        wait_idle();

        // Loads from word 0x100 containing 0x80AA_BBCC, immediate ack
        mem_rdata = 32'h80AA_BBCC;
        ack_delay = 0;
        issue(OP_LD, 3'b000, 32'h0000_0103, 32'h0, 1, 32'hFFFF_FF80, 0, 2, 1, 0, 32'h100, 0, 4'b0000);
        wait_idle();
        issue(OP_LD, 3'b100, 32'h0000_0103, 32'h0, 1, 32'h0000_0080, 0, 2, 1, 0, 32'h100, 0, 4'b0000);
        wait_idle();
        issue(OP_LD, 3'b001, 32'h0000_0102, 32'h0, 1, 32'hFFFF_80AA, 0, 2, 1, 0, 32'h100, 0, 4'b0000);
        wait_idle();
        issue(OP_LD, 3'b101, 32'h0000_0102, 32'h0, 1, 32'h0000_80AA, 0, 2, 1, 0, 32'h100, 0, 4'b0000);
        wait_idle();
        issue(OP_LD, 3'b000, 32'h0000_0101, 32'h0, 1, 32'hFFFF_FFBB, 0, 2, 1, 0, 32'h100, 0, 4'b0000);
        wait_idle();

        // SH with ack on the 4th request cycle
        ack_delay = 3;
        issue(OP_ST, 3'b001, 32'h0000_0202, 32'hDEAD_BEEF, 1, 32'h0, 0, 5, 1, 1, 32'h200, 32'hBEEF_BEEF, 4'b1100);
        wait_idle();
        chk("sh_req_len", 32'(last_req_len), 32'd4);

        // SB lane 1, ack on 2nd cycle
        ack_delay = 1;
        issue(OP_ST, 3'b000, 32'h0000_0201, 32'h1234_56A5, 1, 32'h0, 0, 3, 1, 1, 32'h200, 32'hA5A5_A5A5, 4'b0010);
        wait_idle();
        chk("sb_req_len", 32'(last_req_len), 32'd2);

        // SW
        ack_delay = 0;
        issue(OP_ST, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 1, 32'h0, 0, 2, 1, 1, 32'h300, 32'hCAFE_F00D, 4'b1111);
        wait_idle();

        // Error paths: no bus activity, 1-cycle latency
        issue(OP_LD, 3'b010, 32'h0000_0301, 32'h0, 1, 32'h0, 1, 1, 0, 0, 0, 0, 0);
        wait_idle();
        issue(OP_LD, 3'b011, 32'h0000_0300, 32'h0, 1, 32'h0, 1, 1, 0, 0, 0, 0, 0);
        wait_idle();
        issue(OP_LD, 3'b001, 32'h0000_0101, 32'h0, 1, 32'h0, 1, 1, 0, 0, 0, 0, 0);
        wait_idle();
        issue(OP_ST, 3'b011, 32'h0000_0300, 32'h1, 1, 32'h0, 1, 1, 0, 0, 0, 0, 0);
        wait_idle();
        issue(OP_ST, 3'b100, 32'h0000_0300, 32'h1, 1, 32'h0, 1, 1, 0, 0, 0, 0, 0);
        wait_idle();

        // Timeout with no ack: 4 request cycles
        mem_rdata = 32'h1357_9BDF;
        ack_delay = 100;
        issue(OP_LD, 3'b010, 32'h0000_0400, 32'h0, 1, 32'h0, 1, 5, 1, 0, 32'h400, 0, 4'b0000);
        wait_idle();
        chk("timeout_req_len", 32'(last_req_len), 32'd4);

        // Ack on the limit cycle wins
        ack_delay = 3;
        issue(OP_LD, 3'b010, 32'h0000_0400, 32'h0, 1, 32'h1357_9BDF, 0, 5, 1, 0, 32'h400, 0, 4'b0000);
        wait_idle();
        chk("ack_at_limit_req_len", 32'(last_req_len), 32'd4);

        // Reset during an SW request: abandoned, no out_valid
        ack_delay = 100;
        issue(OP_ST, 3'b010, 32'h0000_0500, 32'h0000_0001, 0, 0, 0, 0, 1, 1, 32'h500, 32'h0000_0001, 4'b1111);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_in_ready2", 32'(in_ready), 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_bus_q", 32'(bus_q.size()), 32'd0);
        issue(OP_ALU, 3'b000, 32'h0000_ABCD, 32'h0, 1, 32'h0000_ABCD, 0, 1, 0, 0, 0, 0, 0);
        wait_idle();
        ack_delay = 0;
        mem_rdata = 32'h0000_7F00;
        issue(OP_LD, 3'b000, 32'h0000_0601, 32'h0, 1, 32'h0000_007F, 0, 2, 1, 0, 32'h600, 0, 4'b0000);
        wait_idle();

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
